// File: rtl/commit_forward_source.sv
// Commit-side forwarding producer: holds one bundle of ALU results, drains it
// into the PRF in lane order through WR_PORTS ports, and forwards every lane
// that has not yet been written so execute can bypass the PRF.

// Per-lane holding register: pending flag plus destination and data.
module commit_forward_lane #(
  parameter int PREG_W = 6,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic              flush,
  input  logic              clr,
  input  logic              lane_valid,
  input  logic [PREG_W-1:0] in_dst,
  input  logic [WORD_W-1:0] in_data,
  output logic              pend,
  output logic [PREG_W-1:0] dst,
  output logic [WORD_W-1:0] data,
  output logic [PREG_W-1:0] fwd_dst,
  output logic [WORD_W-1:0] fwd_data
);
  // Flush beats a capture beats a drain; preg 0 is never pending.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend <= 1'b0;
      dst  <= '0;
      data <= '0;
    end else begin
      if (flush)     pend <= 1'b0;
      else if (load) pend <= lane_valid && (in_dst != '0);
      else if (clr)  pend <= 1'b0;
      if (load) begin
        dst  <= in_dst;
        data <= in_data;
      end
    end
  end

  // Bypass straight from registers, held through the PRF write cycle.
  assign fwd_dst  = pend ? dst  : '0;
  assign fwd_data = pend ? data : '0;
endmodule

module commit_forward_source #(
  parameter int ALU_NUM  = 2,
  parameter int WR_PORTS = 1,
  parameter int PREG_W   = 6,
  parameter int WORD_W   = 32
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ALU_NUM-1:0]         in_lane_valid,
  input  logic [ALU_NUM*PREG_W-1:0]  in_dst,
  input  logic [ALU_NUM*WORD_W-1:0]  in_data,
  output logic [ALU_NUM*PREG_W-1:0]  fwd_dst,
  output logic [ALU_NUM*WORD_W-1:0]  fwd_data,
  output logic [WR_PORTS-1:0]        prf_we,
  output logic [WR_PORTS*PREG_W-1:0] prf_waddr,
  output logic [WR_PORTS*WORD_W-1:0] prf_wdata,
  input  logic                       flush,
  output logic                       busy
);
  localparam int CNT_W = $clog2(ALU_NUM + 1);

  logic [ALU_NUM-1:0]              pend, sel;
  logic [ALU_NUM-1:0][PREG_W-1:0]  dst_q, in_dst_a, fwd_dst_a;
  logic [ALU_NUM-1:0][WORD_W-1:0]  data_q, in_data_a, fwd_data_a;
  logic [WR_PORTS-1:0][PREG_W-1:0] waddr_a;
  logic [WR_PORTS-1:0][WORD_W-1:0] wdata_a;
  logic [CNT_W-1:0]                npend, cnt;
  logic                            accept;

  assign in_dst_a  = in_dst;
  assign in_data_a = in_data;
  assign fwd_dst   = fwd_dst_a;
  assign fwd_data  = fwd_data_a;
  assign prf_waddr = waddr_a;
  assign prf_wdata = wdata_a;

  // A bundle arriving alongside flush is dropped outright.
  assign accept = in_valid && in_ready && !flush;

  genvar g;
  generate
    for (g = 0; g < ALU_NUM; g++) begin : g_lane
      commit_forward_lane #(.PREG_W(PREG_W), .WORD_W(WORD_W)) u_lane (
        .clk        (clk),
        .resetn     (resetn),
        .load       (accept),
        .flush      (flush),
        .clr        (sel[g]),
        .lane_valid (in_lane_valid[g]),
        .in_dst     (in_dst_a[g]),
        .in_data    (in_data_a[g]),
        .pend       (pend[g]),
        .dst        (dst_q[g]),
        .data       (data_q[g]),
        .fwd_dst    (fwd_dst_a[g]),
        .fwd_data   (fwd_data_a[g])
      );
    end
  endgenerate

  // Map the lowest-indexed pending lanes onto write ports in order.
  always_comb begin
    prf_we  = '0;
    waddr_a = '0;
    wdata_a = '0;
    sel     = '0;
    cnt     = '0;
    for (int i = 0; i < ALU_NUM; i++) begin
      if (pend[i] && (cnt < CNT_W'(WR_PORTS))) begin
        sel[i] = 1'b1;
        for (int k = 0; k < WR_PORTS; k++) begin
          if (cnt == CNT_W'(k)) begin
            prf_we[k]  = 1'b1;
            waddr_a[k] = dst_q[i];
            wdata_a[k] = data_q[i];
          end
        end
        cnt = cnt + CNT_W'(1);
      end
    end
  end

  // Ready when this cycle's drain empties the buffer (zero-bubble refill).
  always_comb begin
    npend = '0;
    for (int i = 0; i < ALU_NUM; i++)
      if (pend[i]) npend = npend + CNT_W'(1);
  end

  assign in_ready = flush || (npend <= CNT_W'(WR_PORTS));
  assign busy     = |pend;
endmodule

// File: tb/tb_commit_forward_source.sv
// Directed bench: vector table for a 1-port instance plus hand-written
// sequences for reset mid-drain and 2-port back-to-back streaming.
module tb_commit_forward_source;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  // 1-write-port instance
  logic        iv, fl, rdy, bsy;
  logic [1:0]  lv;
  logic [11:0] idst, fdst;
  logic [63:0] idat, fdat;
  logic [0:0]  we;
  logic [5:0]  wa;
  logic [31:0] wd;

  // 2-write-port instance
  logic        iv2, fl2, rdy2, bsy2;
  logic [1:0]  lv2, we2;
  logic [11:0] idst2, fdst2, wa2;
  logic [63:0] idat2, fdat2, wd2;

  commit_forward_source #(.ALU_NUM(2), .WR_PORTS(1), .PREG_W(6), .WORD_W(32)) u1 (
    .clk(clk), .resetn(resetn), .in_valid(iv), .in_ready(rdy),
    .in_lane_valid(lv), .in_dst(idst), .in_data(idat),
    .fwd_dst(fdst), .fwd_data(fdat), .prf_we(we), .prf_waddr(wa),
    .prf_wdata(wd), .flush(fl), .busy(bsy));

  commit_forward_source #(.ALU_NUM(2), .WR_PORTS(2), .PREG_W(6), .WORD_W(32)) u2 (
    .clk(clk), .resetn(resetn), .in_valid(iv2), .in_ready(rdy2),
    .in_lane_valid(lv2), .in_dst(idst2), .in_data(idat2),
    .fwd_dst(fdst2), .fwd_data(fdat2), .prf_we(we2), .prf_waddr(wa2),
    .prf_wdata(wd2), .flush(fl2), .busy(bsy2));

  typedef struct {
    logic        iv;
    logic [1:0]  lv;
    logic [5:0]  d0, d1;
    logic [31:0] x0, x1;
    logic        fl;
    logic        rdy, bsy;
    logic [5:0]  fd0, fd1;
    logic [31:0] fx0, fx1;
    logic        we;
    logic [5:0]  wa;
    logic [31:0] wd;
  } vec_t;

  int errors = 0;
  int checks = 0;

  function automatic vec_t mk(logic iv_, logic [1:0] lv_, logic [5:0] d0_, logic [5:0] d1_,
                              logic [31:0] x0_, logic [31:0] x1_, logic fl_,
                              logic rdy_, logic bsy_, logic [5:0] fd0_, logic [5:0] fd1_,
                              logic [31:0] fx0_, logic [31:0] fx1_,
                              logic we_, logic [5:0] wa_, logic [31:0] wd_);
    vec_t v;
    v.iv = iv_; v.lv = lv_; v.d0 = d0_; v.d1 = d1_; v.x0 = x0_; v.x1 = x1_; v.fl = fl_;
    v.rdy = rdy_; v.bsy = bsy_; v.fd0 = fd0_; v.fd1 = fd1_; v.fx0 = fx0_; v.fx1 = fx1_;
    v.we = we_; v.wa = wa_; v.wd = wd_;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle1();
    iv = 1'b0; lv = 2'b00; idst = '0; idat = '0; fl = 1'b0;
  endtask

  task automatic idle2();
    iv2 = 1'b0; lv2 = 2'b00; idst2 = '0; idat2 = '0; fl2 = 1'b0;
  endtask

  vec_t tbl[19];

  initial begin
    idle1();
    idle2();

    // idle / main drain / gating / duplicate / zero-bubble / flush
    tbl[0]  = mk(0,2'b00,0,0,0,0,0,       1,0, 0,0,0,0,             0,0,0);
    tbl[1]  = mk(1,2'b11,5,9,'h11,'h22,0, 1,0, 0,0,0,0,             0,0,0);
    tbl[2]  = mk(0,2'b00,0,0,0,0,0,       0,1, 5,9,'h11,'h22,       1,5,'h11);
    tbl[3]  = mk(0,2'b00,0,0,0,0,0,       1,1, 0,9,0,'h22,          1,9,'h22);
    tbl[4]  = mk(0,2'b00,0,0,0,0,0,       1,0, 0,0,0,0,             0,0,0);
    tbl[5]  = mk(1,2'b01,0,3,'h55,'h66,0, 1,0, 0,0,0,0,             0,0,0);
    tbl[6]  = mk(0,2'b00,0,0,0,0,0,       1,0, 0,0,0,0,             0,0,0);
    tbl[7]  = mk(1,2'b11,7,7,'hA,'hB,0,   1,0, 0,0,0,0,             0,0,0);
    tbl[8]  = mk(0,2'b00,0,0,0,0,0,       0,1, 7,7,'hA,'hB,         1,7,'hA);
    tbl[9]  = mk(0,2'b00,0,0,0,0,0,       1,1, 0,7,0,'hB,           1,7,'hB);
    tbl[10] = mk(1,2'b11,5,9,'h11,'h22,0, 1,0, 0,0,0,0,             0,0,0);
    tbl[11] = mk(1,2'b11,3,4,'h33,'h44,0, 0,1, 5,9,'h11,'h22,       1,5,'h11);
    tbl[12] = mk(1,2'b11,3,4,'h33,'h44,0, 1,1, 0,9,0,'h22,          1,9,'h22);
    tbl[13] = mk(0,2'b00,0,0,0,0,0,       0,1, 3,4,'h33,'h44,       1,3,'h33);
    tbl[14] = mk(0,2'b00,0,0,0,0,0,       1,1, 0,4,0,'h44,          1,4,'h44);
    tbl[15] = mk(0,2'b00,0,0,0,0,0,       1,0, 0,0,0,0,             0,0,0);
    tbl[16] = mk(1,2'b11,5,9,'h11,'h22,0, 1,0, 0,0,0,0,             0,0,0);
    tbl[17] = mk(1,2'b11,3,4,'h33,'h44,1, 1,1, 5,9,'h11,'h22,       1,5,'h11);
    tbl[18] = mk(0,2'b00,0,0,0,0,0,       1,0, 0,0,0,0,             0,0,0);

    // Power-up reset state
    #2;
    chk("rst_ready", rdy, 1);
    chk("rst_busy", bsy, 0);
    chk("rst_fwd_dst", fdst, 0);
    chk("rst_fwd_data", fdat, 0);
    chk("rst_we", we, 0);
    chk("rst_waddr", wa, 0);
    chk("rst_wdata", wd, 0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      iv = tbl[i].iv; lv = tbl[i].lv; fl = tbl[i].fl;
      idst = {tbl[i].d1, tbl[i].d0};
      idat = {tbl[i].x1, tbl[i].x0};
      #1;
      chk($sformatf("v%0d_ready", i), rdy, tbl[i].rdy);
      chk($sformatf("v%0d_busy", i), bsy, tbl[i].bsy);
      chk($sformatf("v%0d_fwd_dst", i), fdst, {tbl[i].fd1, tbl[i].fd0});
      chk($sformatf("v%0d_fwd_data", i), fdat, {tbl[i].fx1, tbl[i].fx0});
      chk($sformatf("v%0d_we", i), we, tbl[i].we);
      chk($sformatf("v%0d_waddr", i), wa, tbl[i].wa);
      chk($sformatf("v%0d_wdata", i), wd, tbl[i].wd);
    end

    // Reset mid-drain with two lanes pending
    @(negedge clk);
    iv = 1'b1; lv = 2'b11; idst = {6'd9, 6'd5}; idat = {32'h22, 32'h11};
    @(negedge clk);
    idle1();
    #1;
    chk("pre_rst_busy", bsy, 1);
    chk("pre_rst_we", we, 1);
    #1;
    resetn = 1'b0;
    #1;
    chk("mid_rst_fwd_dst", fdst, 0);
    chk("mid_rst_fwd_data", fdat, 0);
    chk("mid_rst_we", we, 0);
    chk("mid_rst_waddr", wa, 0);
    chk("mid_rst_wdata", wd, 0);
    chk("mid_rst_ready", rdy, 1);
    chk("mid_rst_busy", bsy, 0);
    @(negedge clk);
    resetn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post_rst%0d_we", c), we, 0);
      chk($sformatf("post_rst%0d_ready", c), rdy, 1);
    end

    // Back-to-back bundles on the 2-port instance: no bubbles
    for (int b = 0; b < 6; b++) begin
      @(negedge clk);
      if (b < 5) begin
        iv2 = 1'b1; lv2 = 2'b11;
        idst2 = {6'(b + 10), 6'(b + 1)};
        idat2 = {32'(b * 16 + 2), 32'(b * 16 + 1)};
      end else begin
        idle2();
      end
      #1;
      chk($sformatf("b2b%0d_ready", b), rdy2, 1);
      if (b == 0) begin
        chk("b2b0_we", we2, 2'b00);
      end else begin
        chk($sformatf("b2b%0d_we", b), we2, 2'b11);
        chk($sformatf("b2b%0d_waddr", b), wa2, {6'(b + 9), 6'(b)});
        chk($sformatf("b2b%0d_wdata", b), wd2, {32'((b - 1) * 16 + 2), 32'((b - 1) * 16 + 1)});
        chk($sformatf("b2b%0d_fwd_dst", b), fdst2, {6'(b + 9), 6'(b)});
      end
    end
    @(negedge clk);
    #1;
    chk("b2b_end_we", we2, 2'b00);
    chk("b2b_end_busy", bsy2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/commit_forward_source.md
Name: commit_forward_source

Overview:
- Commit-side producer for the forwarding network. Drives the `commit` modport (`dst`, `data`) of the forward interface.
- Latches one bundle of ALU_NUM results from execute through a valid/ready handshake.
- Drains the bundle into the physical register file through WR_PORTS write ports, in lane order.
- Forwards every lane that is not yet written, so execute can bypass the PRF.

Parameters:
- ALU_NUM, 2, result lanes per bundle; equals the forward interface width.
- WR_PORTS, 1, PRF write ports; must satisfy 1 <= WR_PORTS <= ALU_NUM.
- PREG_W, 6, physical register address width (preg_addr_t). Preg 0 means "no destination".
- WORD_W, 32, data width (word_t).

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- in_valid  in  1  execute presents a bundle.
- in_ready  out  1  block accepts the bundle this cycle.
- in_lane_valid  in  ALU_NUM  per-lane result present.
- in_dst  in  ALU_NUM*PREG_W  per-lane destination preg.
- in_data  in  ALU_NUM*WORD_W  per-lane result.
- fwd_dst  out  ALU_NUM*PREG_W  forward interface `dst` (commit modport).
- fwd_data  out  ALU_NUM*WORD_W  forward interface `data` (commit modport).
- prf_we  out  WR_PORTS  PRF write enables.
- prf_waddr  out  WR_PORTS*PREG_W  PRF write addresses.
- prf_wdata  out  WR_PORTS*WORD_W  PRF write data.
- flush  in  1  synchronous discard of buffered bundle.
- busy  out  1  at least one lane pending.

Behaviour:
State
- Holding register per lane: pend[i], dst[i], data[i].
- A lane whose dst == 0 is never pending. It is dropped at capture.

Reset (resetn=0, asynchronous)
- All pend <= 0 and all dst/data <= 0 immediately.
- Outputs during and after reset:
  - fwd_dst = 0 and fwd_data = 0.
  - prf_we = 0, prf_waddr = 0, prf_wdata = 0.
  - in_ready = 1.
  - busy = 0.
- Reset mid-drain abandons the remaining lanes. No partial writes follow.

Drain (combinational, from current pend)
- Select the lowest-indexed pending lanes, at most WR_PORTS of them.
- Write port k gets the k-th selected lane: we = 1, waddr = dst, wdata = data.
- Unused ports: we = 0, waddr = 0, wdata = 0.
- The selected lanes clear pend at the clock edge.

in_ready
- in_ready = 1 when, after this cycle's drain, no lane remains pending. That is: the number of pending lanes <= WR_PORTS.
- in_ready is forced to 1 when flush is asserted.
- Zero-bubble: a bundle is accepted in the same cycle the last lanes drain.

Accept (in_valid & in_ready)
- At the edge, each lane loads dst/data.
- pend[i] = in_lane_valid[i] & (in_dst[i] != 0).

Forwarding
- fwd_dst[i] = pend[i] ? dst[i] : 0.
- fwd_data[i] = pend[i] ? data[i] : 0.
- A lane is forwarded through the cycle of its PRF write, inclusive. The PRF write becomes visible the next cycle, so there is no hole between the bypass dropping and the PRF holding the value.
- Forwarding is driven purely from registers. There is no combinational path from in_* to fwd_*.

Flush (synchronous)
- At the edge all pend <= 0, even though this cycle's writes still issue.
- A bundle accepted in the same cycle as flush is discarded. in_valid is ignored for that cycle.

busy
- busy = OR(pend).

Latency
- A captured lane appears on fwd the next cycle.
- It is written to the PRF within ceil(lane_rank / WR_PORTS) cycles, counting from that cycle as cycle 1.

Duplicate dst
- Lanes with equal dst are written in lane order. The higher lane wins in PRF.
- Both lanes appear on fwd. Resolving priority between them is the forward unit's job.

Test Plan:
- Reset: drive resetn=0 mid-operation with 2 lanes pending -> outputs zero within the same cycle; after release, in_ready=1 and no prf_we pulses.
- WR_PORTS=1, bundle {lane0 dst=5 data=0x11, lane1 dst=9 data=0x22}:
  - Cycle 1: fwd shows both lanes; prf writes p5=0x11; in_ready=0.
  - Cycle 2: fwd shows only lane1; prf writes p9=0x22; in_ready=1.
  - Cycle 3: fwd=0.
- Back-to-back with WR_PORTS=2, in_valid held high with consecutive bundles -> in_ready stays 1, each bundle is written to the PRF the cycle after capture, no bubbles.
- Lane gating: lane0 dst=0 and lane1 in_lane_valid=0 -> nothing pending, fwd=0, prf_we=0, busy=0.
- Flush with WR_PORTS=1 and both lanes pending, flush together with a new in_valid:
  - That cycle: p5 is written.
  - Next cycle: pend=0, the new bundle is dropped, fwd=0.
- Duplicate dst=7 on both lanes (0xA, then 0xB), WR_PORTS=1 -> PRF writes 0xA, then 0xB; fwd_dst[0] = fwd_dst[1] = 7 during the first drain cycle.
